// File: rtl/csa_accum_ctrl.sv
// Carry-save multi-operand accumulator with a multicycle final carry-propagate conversion.
// Optional macro CSA_ACC_OVF_EN builds the exact unsigned-overflow tracking for out_ovf.
module csa_accum_ctrl #(
  parameter int unsigned CPA_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_ovf,
  output logic [7:0]  op_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, DONE} state_t;

`ifdef CSA_ACC_OVF_EN
  localparam int CW = 16;
`else
  localparam int CW = 15;
`endif

  // Counter spans the CONVERT entry cycle plus CPA_CYCLES settle cycles.
  localparam logic [3:0] CNT_LOAD = 4'(CPA_CYCLES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state;
  logic [15:0]     s_q;
  logic [CW-1:0]   c_q;
  logic [3:0]      cnt_q;
  logic [15:0]     d_w;
  logic [15:0]     s_nxt;
  logic [CW-1:0]   c_nxt;

  assign d_w   = {c_q[14:0], 1'b0};
  assign s_nxt = s_q ^ d_w ^ in_data;
  assign c_nxt = CW'((s_q & d_w) | (s_q & in_data) | (d_w & in_data));

`ifdef CSA_ACC_OVF_EN
  logic [16:0] cpa_w;
  assign cpa_w = {1'b0, s_q} + {1'b0, d_w};
`else
  logic [15:0] cpa_w;
  assign cpa_w = s_q + d_w;
`endif

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      out_sum  <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s_q      <= in_data;
          c_q      <= '0;
          op_count <= 8'd1;
          if (in_last) begin
            state <= CONVERT;
            cnt_q <= CNT_LOAD;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: if (in_valid) begin
          s_q      <= s_nxt;
          c_q      <= c_nxt;
          op_count <= sat_inc(op_count);
          if (in_last) begin
            state <= CONVERT;
            cnt_q <= CNT_LOAD;
          end
        end
        CONVERT: begin
          if (cnt_q == 4'd0) begin
            out_sum <= cpa_w[15:0];
            state   <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic ovf_sticky;

  // Every carry leaving bit 15 has weight 2^16, so OR-ing them is an exact overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid) ovf_sticky <= 1'b0;
        ACCUM:   if (in_valid) ovf_sticky <= ovf_sticky | c_q[15];
        CONVERT: if (cnt_q == 4'd0) out_ovf <= ovf_sticky | c_q[15] | cpa_w[16];
        default: ;
      endcase
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl: batch sums modelled with plain integer arithmetic.
module tb_csa_accum_ctrl;
  localparam int CPA = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic [7:0]  op_count;
  logic        busy;

  csa_accum_ctrl #(.CPA_CYCLES(CPA)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    logic [7:0]  cnt;
    int          acc;
  } exp_t;
  exp_t q[$];

  longint unsigned bsum = 0;
  int              bcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered and left at a negedge; gap idle cycles precede the beat.
  task automatic send(input logic [15:0] d, input bit last, input int gap);
    int to = 0;
    exp_t e;
    repeat (gap) @(negedge clk);
    while (!in_ready && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    bsum += d;
    bcnt++;
    if (last) begin
      e.sum = bsum[15:0];
`ifdef CSA_ACC_OVF_EN
      e.ovf = (bsum >= 64'd65536);
`else
      e.ovf = 1'b0;
`endif
      e.cnt = (bcnt > 255) ? 8'd255 : 8'(bcnt);
      e.acc = cyc + 1;
      q.push_back(e);
      bsum = 0;
      bcnt = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready);
    int to = 0;
    while (busy && to < 1000) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      to++;
    end
    out_ready = 1'b1;
    if (busy) begin
      check("done_timeout", 0, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sum"},   out_sum,   0);
    check({tag, "_out_ovf"},   out_ovf,   0);
    check({tag, "_op_count"},  op_count,  0);
    check({tag, "_busy"},      busy,      0);
  endtask

  // Monitor: compare each result as out_valid rises.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_ovf", out_ovf, e.ovf);
        check("op_count", op_count, e.cnt);
        check("latency", cyc - e.acc, CPA + 1);
        check("in_ready_in_done", in_ready, 0);
      end
    end
    prev_v = out_valid;
  end

  initial begin
    int len;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    send(16'h1234, 1, 0);
    wait_done(0);

    send(16'h0001, 0, 0);
    send(16'h0002, 0, 0);
    send(16'h0003, 1, 0);
    wait_done(0);
    check("op_count_held_idle", op_count, 3);

    send(16'hFFFF, 0, 0);
    send(16'h0001, 1, 0);
    wait_done(0);
    repeat (3) send(16'h8000, 0, 0);
    send(16'h8000, 1, 0);
    wait_done(0);

    // Result held while the consumer stalls.
    out_ready = 1'b0;
    send(16'h0100, 0, 0);
    send(16'h0200, 1, 1);
    begin
      int to = 0;
      while (!out_valid && to < 50) begin
        @(negedge clk);
        to++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_sum", out_sum, 16'h0300);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    @(negedge clk);

    // Asynchronous abort mid-batch.
    send(16'h0007, 0, 0);
    send(16'h0009, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    bsum = 0;
    bcnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(16'h0005, 1, 0);
    wait_done(0);

    // Long batch exercising op_count saturation.
    for (int i = 1; i <= 300; i++) send(16'h0001, (i == 300), $urandom_range(0, 2));
    wait_done(0);

    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(1, 8);
      for (int i = 1; i <= len; i++)
        send(16'($urandom), (i == len), ($urandom_range(0, 3) == 0) ? 1 : 0);
      wait_done(1);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
